// File: rtl/scr1_tapc_pkg.sv
// -----------------------------------------------------------------------------
// scr1_tapc_pkg
// Shared definitions for the banked TAP data-register block:
//   - scr1_tapc_sel_w()      : width of the channel/bypass select bus
//   - scr1_tapc_bypass_sel() : first select value that maps to bypass
//   - type_scr1_tapc_dr_op_e : the single operation chosen from the
//                              capture/shift/update strobes (capture wins,
//                              then shift, then update)
// -----------------------------------------------------------------------------
package scr1_tapc_pkg;

  typedef enum logic [1:0] {
    SCR1_TAPC_DR_OP_NONE    = 2'd0,
    SCR1_TAPC_DR_OP_CAPTURE = 2'd1,
    SCR1_TAPC_DR_OP_SHIFT   = 2'd2,
    SCR1_TAPC_DR_OP_UPDATE  = 2'd3
  } type_scr1_tapc_dr_op_e;

  // One extra code point beyond the channels is reserved for bypass.
  function automatic int unsigned scr1_tapc_sel_w(input int unsigned dr_num);
    return $clog2(dr_num + 32'd1);
  endfunction

  // Channel indices run 0..dr_num-1, so dr_num itself is the bypass code.
  function automatic int unsigned scr1_tapc_bypass_sel(input int unsigned dr_num);
    return dr_num;
  endfunction

endpackage : scr1_tapc_pkg

// File: rtl/scr1_tapc_dr_shadow.sv
// -----------------------------------------------------------------------------
// scr1_tapc_dr_shadow
// One channel of the DR bank: shadow register loaded from the shared shift
// register, a valid flag handshaken with the consumer, and (with macro
// SCR1_TAPC_DR_OVF_EN) a sticky overrun flag.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   upd            : update strobe already decoded for this channel
//   upd_data       : value to load (shared shift register)
//   upd_ack        : consumer has taken the current value
//   shadow         : registered shadow value
//   valid          : registered "new update pending"
//   upd_ovf        : sticky overrun (macro only)
//   ovf_clr        : clears upd_ovf (macro only)
// -----------------------------------------------------------------------------
module scr1_tapc_dr_shadow #(
  parameter int unsigned          SCR1_WIDTH       = 8,
  parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd,
  input  logic [SCR1_WIDTH-1:0] upd_data,
  input  logic                  upd_ack,
  output logic [SCR1_WIDTH-1:0] shadow,
  output logic                  valid
`ifdef SCR1_TAPC_DR_OVF_EN
  ,
  output logic                  upd_ovf,
  input  logic                  ovf_clr
`endif
);

  // Shadow register: follows the shift register on every update, even when
  // the previous value was never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= SCR1_RESET_VALUE;
    end else if (upd) begin
      shadow <= upd_data;
    end else begin
      shadow <= shadow;
    end
  end

  // Valid flag: an update in the same cycle as an ack keeps it set, because
  // the ack consumed the older value and a fresh one has just arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (upd) begin
      valid <= 1'b1;
    end else if (upd_ack) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

`ifdef SCR1_TAPC_DR_OVF_EN
  logic overrun_s;

  // An overrun is an update landing on an unconsumed, un-acked value.
  always_comb begin
    overrun_s = upd & valid & ~upd_ack;
  end

  // Sticky overrun flag; a new overrun outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_ovf <= 1'b0;
    end else if (overrun_s) begin
      upd_ovf <= 1'b1;
    end else if (ovf_clr) begin
      upd_ovf <= 1'b0;
    end else begin
      upd_ovf <= upd_ovf;
    end
  end
`endif

endmodule : scr1_tapc_dr_shadow

// File: rtl/scr1_tapc_dr_bank.sv
// -----------------------------------------------------------------------------
// scr1_tapc_dr_bank
// Banked JTAG data-register block: one shared capture/shift register serves
// SCR1_DR_NUM channels, each with its own shadow register and valid/ack
// handshake. Selects at or above SCR1_DR_NUM route through a 1-bit bypass.
// Optional feature macro: SCR1_TAPC_DR_OVF_EN (per-channel sticky overrun).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   fsm_dr_capture/shift/update : TAP FSM strobes (capture > shift > update)
//   dr_sel                   : channel index, >= SCR1_DR_NUM means bypass
//   din_serial / dout_serial : TDI / TDO
//   din_parallel             : capture data, channel k at [k*W +: W]
//   dout_parallel            : shadow outputs, same packing
//   upd_valid / upd_ack      : per-channel update handshake
//   upd_ovf / ovf_clr        : per-channel overrun flag and clear (macro only)
// -----------------------------------------------------------------------------
module scr1_tapc_dr_bank
  import scr1_tapc_pkg::*;
#(
  parameter int unsigned           SCR1_WIDTH       = 8,
  parameter int unsigned           SCR1_DR_NUM      = 4,
  parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0,
  parameter int unsigned           SCR1_SEL_W       = scr1_tapc_sel_w(SCR1_DR_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fsm_dr_capture,
  input  logic                              fsm_dr_shift,
  input  logic                              fsm_dr_update,
  input  logic [SCR1_SEL_W-1:0]             dr_sel,
  input  logic                              din_serial,
  input  logic [SCR1_DR_NUM*SCR1_WIDTH-1:0] din_parallel,
  output logic                              dout_serial,
  output logic [SCR1_DR_NUM*SCR1_WIDTH-1:0] dout_parallel,
  output logic [SCR1_DR_NUM-1:0]            upd_valid,
  input  logic [SCR1_DR_NUM-1:0]            upd_ack
`ifdef SCR1_TAPC_DR_OVF_EN
  ,
  output logic [SCR1_DR_NUM-1:0]            upd_ovf,
  input  logic [SCR1_DR_NUM-1:0]            ovf_clr
`endif
);

  localparam logic [SCR1_SEL_W-1:0] BYPASS_SEL = SCR1_SEL_W'(scr1_tapc_bypass_sel(SCR1_DR_NUM));

  type_scr1_tapc_dr_op_e  dr_op_s;
  logic                   sel_ch_s;
  logic [SCR1_WIDTH-1:0]  cap_data_s;
  logic [SCR1_WIDTH-1:0]  shift_next_s;
  logic [SCR1_WIDTH-1:0]  shift_reg_r;
  logic                   bypass_r;
  logic [SCR1_DR_NUM-1:0] upd_s;

  // Collapse the strobes into one operation; capture > shift > update.
  always_comb begin
    dr_op_s = SCR1_TAPC_DR_OP_NONE;
    if (fsm_dr_capture) begin
      dr_op_s = SCR1_TAPC_DR_OP_CAPTURE;
    end else if (fsm_dr_shift) begin
      dr_op_s = SCR1_TAPC_DR_OP_SHIFT;
    end else if (fsm_dr_update) begin
      dr_op_s = SCR1_TAPC_DR_OP_UPDATE;
    end else begin
      dr_op_s = SCR1_TAPC_DR_OP_NONE;
    end
  end

  // Channel vs bypass decode.
  always_comb begin
    sel_ch_s = (dr_sel < BYPASS_SEL);
  end

  // Capture-data mux; the loop keeps the index in range for any select value.
  always_comb begin
    cap_data_s = SCR1_RESET_VALUE;
    for (int k = 0; k < int'(SCR1_DR_NUM); k++) begin
      if (dr_sel == SCR1_SEL_W'(k)) begin
        cap_data_s = din_parallel[k*SCR1_WIDTH +: SCR1_WIDTH];
      end else begin
        cap_data_s = cap_data_s;
      end
    end
  end

  // A 1-bit register just takes TDI; wider ones shift right, TDI into MSB.
  generate
    if (SCR1_WIDTH == 1) begin : g_shift_w1
      assign shift_next_s = din_serial;
    end else begin : g_shift_wn
      assign shift_next_s = {din_serial, shift_reg_r[SCR1_WIDTH-1:1]};
    end
  endgenerate

  // Shared capture/shift register; it holds while bypass is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg_r <= SCR1_RESET_VALUE;
    end else if (sel_ch_s) begin
      case (dr_op_s)
        SCR1_TAPC_DR_OP_CAPTURE: shift_reg_r <= cap_data_s;
        SCR1_TAPC_DR_OP_SHIFT:   shift_reg_r <= shift_next_s;
        default:                 shift_reg_r <= shift_reg_r;
      endcase
    end else begin
      shift_reg_r <= shift_reg_r;
    end
  end

  // Bypass bit: captures 0, shifts TDI, ignores update.
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_r <= 1'b0;
    end else if (!sel_ch_s) begin
      case (dr_op_s)
        SCR1_TAPC_DR_OP_CAPTURE: bypass_r <= 1'b0;
        SCR1_TAPC_DR_OP_SHIFT:   bypass_r <= din_serial;
        default:                 bypass_r <= bypass_r;
      endcase
    end else begin
      bypass_r <= bypass_r;
    end
  end

  // TDO follows dr_sel combinationally; both sources are registers.
  always_comb begin
    if (sel_ch_s) begin
      dout_serial = shift_reg_r[0];
    end else begin
      dout_serial = bypass_r;
    end
  end

  generate
    for (genvar k = 0; k < int'(SCR1_DR_NUM); k++) begin : g_ch
      assign upd_s[k] = sel_ch_s && (dr_op_s == SCR1_TAPC_DR_OP_UPDATE)
                        && (dr_sel == SCR1_SEL_W'(k));

      scr1_tapc_dr_shadow #(
        .SCR1_WIDTH       (SCR1_WIDTH),
        .SCR1_RESET_VALUE (SCR1_RESET_VALUE)
      ) i_shadow (
        .clk      (clk),
        .rst      (rst),
        .upd      (upd_s[k]),
        .upd_data (shift_reg_r),
        .upd_ack  (upd_ack[k]),
        .shadow   (dout_parallel[k*SCR1_WIDTH +: SCR1_WIDTH]),
        .valid    (upd_valid[k])
`ifdef SCR1_TAPC_DR_OVF_EN
        ,
        .upd_ovf  (upd_ovf[k]),
        .ovf_clr  (ovf_clr[k])
`endif
      );
    end
  endgenerate

endmodule : scr1_tapc_dr_bank

// File: tb/tb_scr1_tapc_dr_bank.sv
// Self-checking bench: a behavioural model of the bank (plain arrays, shift by
// arithmetic) is stepped on every posedge, a negedge process compares all DUT
// outputs against it, and directed scenarios add hand-computed literal checks.
module tb_scr1_tapc_dr_bank;

  localparam int W = 8;
  localparam int N = 4;
  localparam int SW = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fsm_dr_capture, fsm_dr_shift, fsm_dr_update;
  logic [SW-1:0] dr_sel;
  logic          din_serial;
  logic [N*W-1:0] din_parallel;
  logic          dout_serial;
  logic [N*W-1:0] dout_parallel;
  logic [N-1:0]  upd_valid;
  logic [N-1:0]  upd_ack;
`ifdef SCR1_TAPC_DR_OVF_EN
  logic [N-1:0]  upd_ovf;
  logic [N-1:0]  ovf_clr;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  // model state
  logic [7:0] m_shift;
  logic       m_byp;
  logic [7:0] m_shadow [N];
  logic [N-1:0] m_valid;
  logic [N-1:0] m_ovf;

  scr1_tapc_dr_bank #(
    .SCR1_WIDTH       (W),
    .SCR1_DR_NUM      (N),
    .SCR1_RESET_VALUE (RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fsm_dr_capture (fsm_dr_capture),
    .fsm_dr_shift   (fsm_dr_shift),
    .fsm_dr_update  (fsm_dr_update),
    .dr_sel         (dr_sel),
    .din_serial     (din_serial),
    .din_parallel   (din_parallel),
    .dout_serial    (dout_serial),
    .dout_parallel  (dout_parallel),
    .upd_valid      (upd_valid),
    .upd_ack        (upd_ack)
`ifdef SCR1_TAPC_DR_OVF_EN
    ,
    .upd_ovf        (upd_ovf),
    .ovf_clr        (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: one transaction per clock from the sampled inputs.
  always @(posedge clk) begin
    int upd_k;
    logic sel_ch;
    upd_k = -1;
    if (rst) begin
      m_shift = RV;
      m_byp   = 1'b0;
      for (int k = 0; k < N; k++) m_shadow[k] = RV;
      m_valid = '0;
      m_ovf   = '0;
    end else begin
      sel_ch = (int'(dr_sel) < N);
      if (fsm_dr_capture) begin
        if (sel_ch) m_shift = din_parallel[int'(dr_sel)*8 +: 8];
        else        m_byp = 1'b0;
      end else if (fsm_dr_shift) begin
        if (sel_ch) m_shift = (m_shift >> 1) | (8'(din_serial) << 7);
        else        m_byp = din_serial;
      end else if (fsm_dr_update && sel_ch) begin
        upd_k = int'(dr_sel);
      end
      for (int k = 0; k < N; k++) begin
        bit ovf_set;
        ovf_set = 1'b0;
        if (k == upd_k) begin
          if (m_valid[k] && !upd_ack[k]) ovf_set = 1'b1;
          m_shadow[k] = m_shift;
          m_valid[k]  = 1'b1;
        end else if (upd_ack[k]) begin
          m_valid[k] = 1'b0;
        end
`ifdef SCR1_TAPC_DR_OVF_EN
        if (ovf_set) m_ovf[k] = 1'b1;
        else if (ovf_clr[k]) m_ovf[k] = 1'b0;
`endif
      end
    end
  end

  // Compare process: every output against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N*W-1:0] exp_par;
      for (int k = 0; k < N; k++) exp_par[k*8 +: 8] = m_shadow[k];
      check("dout_serial", 64'(dout_serial), 64'((int'(dr_sel) < N) ? m_shift[0] : m_byp));
      check("dout_parallel", 64'(dout_parallel), 64'(exp_par));
      check("upd_valid", 64'(upd_valid), 64'(m_valid));
`ifdef SCR1_TAPC_DR_OVF_EN
      check("upd_ovf", 64'(upd_ovf), 64'(m_ovf));
`endif
    end
  end

  task automatic idle();
    fsm_dr_capture = 1'b0; fsm_dr_shift = 1'b0; fsm_dr_update = 1'b0;
    upd_ack = '0; din_serial = 1'b0;
`ifdef SCR1_TAPC_DR_OVF_EN
    ovf_clr = '0;
`endif
  endtask

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic cap, input logic sh, input logic upd, input logic tdi);
    idle();
    fsm_dr_capture = cap; fsm_dr_shift = sh; fsm_dr_update = upd; din_serial = tdi;
    tick();
    idle();
  endtask

  initial begin
    logic [7:0] tdo_seq;
    logic [7:0] tdi_pat;
    logic [7:0] exp_tdo;
    idle();
    rst = 1'b1; dr_sel = '0; din_parallel = '0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    check("rst_shadows", 64'(dout_parallel), 64'h0000_0000_A5A5_A5A5);
    check("rst_valid", 64'(upd_valid), 64'h0);
    check("rst_tdo_sel0", 64'(dout_serial), 64'h1);
    dr_sel = 3'd4;
    #1;
    check("rst_tdo_byp", 64'(dout_serial), 64'h0);

    // capture 3C on channel 2, shift in F0 LSB-first
    dr_sel = 3'd2;
    din_parallel = {8'h00, 8'h3C, 8'h11, 8'h00};
    op(1'b1, 1'b0, 1'b0, 1'b0);
    tdi_pat = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      tdo_seq[i] = dout_serial;
      op(1'b0, 1'b1, 1'b0, tdi_pat[i]);
    end
    exp_tdo = 8'h3C;
    check("tdo_seq", 64'(tdo_seq), 64'(exp_tdo));
    op(1'b0, 1'b0, 1'b1, 1'b0);
    check("upd_ch2", 64'(dout_parallel), 64'h0000_0000_A5F0_A5A5);
    check("upd_valid2", 64'(upd_valid), 64'h4);

    // overrun on channel 1
    dr_sel = 3'd1;
    op(1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 1'b0);
    din_parallel[15:8] = 8'h22;
    op(1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_shadow1", 64'(dout_parallel[15:8]), 64'h22);
    check("ovr_valid", 64'(upd_valid), 64'h6);
`ifdef SCR1_TAPC_DR_OVF_EN
    check("ovf1_set", 64'(upd_ovf), 64'h2);
    ovf_clr = 4'b0010; tick(); idle();
    check("ovf1_clr", 64'(upd_ovf), 64'h0);
`endif
    fsm_dr_update = 1'b1; upd_ack = 4'b0010; tick(); idle();
    check("upd_ack_same", 64'(upd_valid[1]), 64'h1);
`ifdef SCR1_TAPC_DR_OVF_EN
    check("upd_ack_no_ovf", 64'(upd_ovf), 64'h0);
`endif
    upd_ack = 4'hF; tick(); idle();
    check("ack_all", 64'(upd_valid), 64'h0);

    // bypass
    dr_sel = 3'd4;
    op(1'b1, 1'b0, 1'b0, 1'b0);
    check("byp_cap", 64'(dout_serial), 64'h0);
    op(1'b0, 1'b1, 1'b0, 1'b1);
    check("byp_s1", 64'(dout_serial), 64'h1);
    op(1'b0, 1'b1, 1'b0, 1'b0);
    check("byp_s2", 64'(dout_serial), 64'h0);
    op(1'b0, 1'b1, 1'b0, 1'b1);
    check("byp_s3", 64'(dout_serial), 64'h1);
    op(1'b0, 1'b0, 1'b1, 1'b0);
    check("byp_upd_valid", 64'(upd_valid), 64'h0);
    check("byp_upd_shadow", 64'(dout_parallel), 64'h0000_0000_A5F0_22A5);

    // reset mid-shift with a pending update
    dr_sel = 3'd0;
    din_parallel[7:0] = 8'h0F;
    op(1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; fsm_dr_shift = 1'b1; tick(); rst = 1'b0; idle();
    check("rst_mid_shadow", 64'(dout_parallel), 64'h0000_0000_A5A5_A5A5);
    check("rst_mid_valid", 64'(upd_valid), 64'h0);
    check("rst_mid_tdo", 64'(dout_serial), 64'h1);

    // capture + update together: capture only
    dr_sel = 3'd3;
    din_parallel[31:24] = 8'h5A;
    op(1'b1, 1'b0, 1'b1, 1'b0);
    check("capupd_valid", 64'(upd_valid), 64'h0);
    check("capupd_tdo", 64'(dout_serial), 64'h0);
    check("capupd_shadow3", 64'(dout_parallel[31:24]), 64'hA5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      fsm_dr_capture = ($urandom_range(0, 7) == 0);
      fsm_dr_shift   = ($urandom_range(0, 1) == 0);
      fsm_dr_update  = ($urandom_range(0, 3) == 0);
      dr_sel         = SW'($urandom_range(0, 7));
      din_serial     = 1'($urandom);
      din_parallel   = N*W'($urandom);
      upd_ack        = N'($urandom) & N'($urandom);
`ifdef SCR1_TAPC_DR_OVF_EN
      ovf_clr        = N'($urandom) & N'($urandom) & N'($urandom);
`endif
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; idle(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule : tb_scr1_tapc_dr_bank
